// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the 2-way set-associative instruction cache:
//   - state_t        : controller states (IDLE, MEM_READ, FILL, FLUSH)
//   - off_w/idx_w/tag_w : address field widths derived from the geometry
//   - word_select    : picks one 32-bit word out of a cache block
// No ports (package).
// -----------------------------------------------------------------------------
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        FILL     = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    // Upper bound on block size accepted by word_select.
    localparam int MAX_BLOCK_WORDS = 64;

    // Byte-offset width: word index bits plus the two byte-in-word bits.
    function automatic int off_w(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int block_words, input int sets);
        return addr_w - off_w(block_words) - idx_w(sets);
    endfunction

    // Block is passed zero-padded to the maximum size; word 0 sits in [31:0].
    function automatic logic [31:0] word_select(input logic [32*MAX_BLOCK_WORDS-1:0] block,
                                                input int sel);
        return block[sel*32 +: 32];
    endfunction

endpackage

// File: rtl/icache_way.sv
// -----------------------------------------------------------------------------
// icache_way
// One way of the instruction cache: data, tag and valid arrays, the tag
// compare for the indexed set, and the word mux for the addressed word.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset (valid bits only)
//   index            : set index of the current lookup / fill
//   tag              : tag to compare against and to store on fill
//   word_sel         : word within the block to present on `word`
//   write_en         : store write_data + tag and set valid at index
//   write_data       : whole block to store
//   clear_valid      : invalidate every set of this way
//   hit              : indexed line is valid and its tag matches
//   valid            : indexed line is valid (used for victim choice)
//   word             : selected word of the indexed line
// -----------------------------------------------------------------------------
module icache_way
    import icache_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int BLOCK_WORDS   = 4,
    parameter int SETS          = 4,
    localparam int IDX_W        = idx_w(SETS),
    localparam int TAG_W        = tag_w(ADDR_W, BLOCK_WORDS, SETS),
    localparam int WSEL_W       = $clog2(BLOCK_WORDS),
    localparam int BLOCK_W      = 32 * BLOCK_WORDS
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [IDX_W-1:0]   index,
    input  logic [TAG_W-1:0]   tag,
    input  logic [WSEL_W-1:0]  word_sel,
    input  logic               write_en,
    input  logic [BLOCK_W-1:0] write_data,
    input  logic               clear_valid,
    output logic               hit,
    output logic               valid,
    output logic [31:0]        word
);

    logic [BLOCK_W-1:0]               data_mem [SETS];
    logic [TAG_W-1:0]                 tag_mem  [SETS];
    logic [SETS-1:0]                  valid_bits;
    logic [32*MAX_BLOCK_WORDS-1:0]    line_padded;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_bits <= '0;
        end else if (clear_valid) begin
            valid_bits <= '0;
        end else if (write_en) begin
            valid_bits[index] <= 1'b1;
        end
    end

    // Data and tags are deliberately not reset; valid bits gate their use.
    always_ff @(posedge clock) begin
        if (write_en) begin
            data_mem[index] <= write_data;
            tag_mem[index]  <= tag;
        end
    end

    assign valid = valid_bits[index];
    assign hit   = valid && (tag_mem[index] == tag);

    always_comb begin
        line_padded                = '0;
        line_padded[BLOCK_W-1:0]   = data_mem[index];
    end

    assign word = word_select(line_padded, int'(word_sel));

endmodule

// File: rtl/icache_2way.sv
// -----------------------------------------------------------------------------
// icache_2way
// 2-way set-associative instruction cache with per-set LRU replacement,
// explicit fetch request and whole-cache flush.
// Optional macro ICACHE_PERF_EN adds saturating hit_count / miss_count ports.
// Ports:
//   clock, reset_n : clock (rising edge), asynchronous active-low reset
//   read           : fetch request valid
//   address        : byte address {tag, set, word, 2'b00}
//   flush          : invalidate all lines
//   instruction    : selected word, valid when read && !busywait
//   busywait       : stall to the fetch stage
//   hit_count      : (ICACHE_PERF_EN) saturating hit counter
//   miss_count     : (ICACHE_PERF_EN) saturating miss counter
//   mem_read       : block read request to instruction memory
//   mem_address    : block address {tag, set}
//   mem_readdata   : block returned by memory, word 0 in [31:0]
//   mem_busywait   : memory busy; data valid on first sampled low
// -----------------------------------------------------------------------------
module icache_2way
    import icache_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int BLOCK_WORDS   = 4,
    parameter int SETS          = 4,
    localparam int OFF_W        = off_w(BLOCK_WORDS),
    localparam int IDX_W        = idx_w(SETS),
    localparam int TAG_W        = tag_w(ADDR_W, BLOCK_WORDS, SETS),
    localparam int BLOCK_W      = 32 * BLOCK_WORDS
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    read,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    flush,
    output logic [31:0]             instruction,
    output logic                    busywait,
`ifdef ICACHE_PERF_EN
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count,
`endif
    output logic                    mem_read,
    output logic [ADDR_W-OFF_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]      mem_readdata,
    input  logic                    mem_busywait
);

    localparam int WSEL_W = OFF_W - 2;

    state_t              state, state_nxt;
    logic [WSEL_W-1:0]   word_idx;
    logic [IDX_W-1:0]    set_idx;
    logic [TAG_W-1:0]    tag_f;
    logic                addr_lsb_unused;

    logic                hit0, hit1, valid0, valid1, hit_any, hit_valid;
    logic [31:0]         word0, word1, hit_word, last_instr;
    logic                victim_way, we0, we1;
    logic [SETS-1:0]     lru;
    logic                flush_pend;
    logic [BLOCK_W-1:0]  fill_buf;

    logic                busy_c, mem_read_c, fill_en, flush_en;

    assign word_idx        = address[OFF_W-1:2];
    assign set_idx         = address[OFF_W+IDX_W-1:OFF_W];
    assign tag_f           = address[ADDR_W-1:OFF_W+IDX_W];
    assign addr_lsb_unused = ^address[1:0];

    // Both ways are looked up in parallel on the indexed set.
    icache_way #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BLOCK_WORDS), .SETS(SETS)) u_way0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .index       (set_idx),
        .tag         (tag_f),
        .word_sel    (word_idx),
        .write_en    (we0),
        .write_data  (fill_buf),
        .clear_valid (flush_en),
        .hit         (hit0),
        .valid       (valid0),
        .word        (word0)
    );

    icache_way #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BLOCK_WORDS), .SETS(SETS)) u_way1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .index       (set_idx),
        .tag         (tag_f),
        .word_sel    (word_idx),
        .write_en    (we1),
        .write_data  (fill_buf),
        .clear_valid (flush_en),
        .hit         (hit1),
        .valid       (valid1),
        .word        (word1)
    );

    assign hit_any   = hit0 | hit1;
    // A flush in the same cycle wins over a hit.
    assign hit_valid = (state == IDLE) && read && hit_any && !flush;
    assign hit_word  = hit0 ? word0 : word1;

    // First invalid way (way0 first), otherwise the least recently used one.
    assign victim_way = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[set_idx]);
    assign we0        = fill_en && !victim_way;
    assign we1        = fill_en &&  victim_way;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy_c     = 1'b0;
        mem_read_c = 1'b0;
        fill_en    = 1'b0;
        flush_en   = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    busy_c    = 1'b1;
                    state_nxt = FLUSH;
                end else if (read && !hit_any) begin
                    busy_c    = 1'b1;
                    state_nxt = MEM_READ;
                end
            end
            MEM_READ: begin
                busy_c     = 1'b1;
                mem_read_c = 1'b1;
                if (!mem_busywait) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                busy_c    = 1'b1;
                fill_en   = 1'b1;
                state_nxt = (flush_pend || flush) ? FLUSH : IDLE;
            end
            FLUSH: begin
                busy_c    = 1'b1;
                flush_en  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The block is captured when memory first reports ready, so it need not
    // stay on mem_readdata during FILL.
    always_ff @(posedge clock) begin
        if ((state == MEM_READ) && !mem_busywait) begin
            fill_buf <= mem_readdata;
        end
    end

    // A flush arriving during a refill is remembered and run right after FILL.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flush_pend <= 1'b0;
        end else if (state == FLUSH) begin
            flush_pend <= 1'b0;
        end else if (flush && ((state == MEM_READ) || (state == FILL))) begin
            flush_pend <= 1'b1;
        end
    end

    // lru[s] names the way that was not used most recently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lru <= '0;
        end else if (flush_en) begin
            lru <= '0;
        end else if (fill_en) begin
            lru[set_idx] <= ~victim_way;
        end else if (hit_valid) begin
            lru[set_idx] <= hit0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_instr <= '0;
        end else if (hit_valid) begin
            last_instr <= hit_word;
        end
    end

    assign instruction = hit_valid ? hit_word : last_instr;
    // Gated so that busywait reads 0 while reset is held even with read high.
    assign busywait    = reset_n & busy_c;
    assign mem_read    = mem_read_c;
    assign mem_address = mem_read_c ? {tag_f, set_idx} : '0;

`ifdef ICACHE_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == FLUSH) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_valid) begin
                hit_count <= sat_inc(hit_count);
            end
            if ((state == IDLE) && (state_nxt == MEM_READ)) begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_icache_2way.sv
// -----------------------------------------------------------------------------
// tb_icache_2way
// Randomised self-checking bench for icache_2way (default geometry).
// A transaction-level cache model (valid/tag/LRU tables and a miss timeline
// derived from the memory wait) sets per-cycle expectations; a single
// negedge process compares the DUT against them.
// -----------------------------------------------------------------------------
module tb_icache_2way;

    localparam int MEM_WAIT = 5;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         read;
    logic [9:0]   address;
    logic         flush;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_PERF_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    icache_2way dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .read         (read),
        .address      (address),
        .flush        (flush),
        .instruction  (instruction),
        .busywait     (busywait),
`ifdef ICACHE_PERF_EN
        .hit_count    (hit_count),
        .miss_count   (miss_count),
`endif
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    // Memory content: 0xA0000000 | block<<8 | word.
    function automatic logic [31:0] mem_word(input int blk, input int w);
        return 32'hA000_0000 | 32'(blk << 8) | 32'(w);
    endfunction

    // Memory: busy for MEM_WAIT cycles after a request appears.
    int mcnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)              mcnt <= 0;
        else if (!mem_read)        mcnt <= 0;
        else if (mcnt < MEM_WAIT)  mcnt <= mcnt + 1;
    end
    assign mem_busywait = mem_read && (mcnt < MEM_WAIT);
    always_comb begin
        mem_readdata = '0;
        for (int w = 0; w < 4; w++) mem_readdata[w*32 +: 32] = mem_word(int'(mem_address), w);
    end

    // Cache model.
    bit          m_valid [4][2];
    int          m_tag   [4][2];
    int          m_lru   [4];
    logic [31:0] last_instr;
    int          m_hits, m_misses;

    // Per-cycle expectations.
    bit          exp_on = 1'b0;
    int          exp_busy;
    bit          exp_mr;
    logic [5:0]  exp_maddr;
    logic [31:0] exp_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_on) begin
            if (exp_busy >= 0) check("busywait", 32'(busywait), 32'(exp_busy));
            check("mem_read", 32'(mem_read), 32'(exp_mr));
            if (exp_mr) check("mem_address", 32'(mem_address), 32'(exp_maddr));
            check("instruction", instruction, exp_instr);
        end
    end

    task automatic step_cycle(input int busy, input bit mr, input logic [5:0] maddr,
                              input logic [31:0] instr);
        exp_busy  = busy;
        exp_mr    = mr;
        exp_maddr = maddr;
        exp_instr = instr;
        exp_on    = 1'b1;
        @(posedge clock);
        #1;
    endtask

    function automatic int sat16(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_flush();
        for (int s = 0; s < 4; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_lru[s]      = 0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // One fetch; flush_at >= 0 raises flush in that MEM_READ cycle.
    task automatic fetch(input logic [9:0] a, input int flush_at);
        int  blk, s, t, w, way, fa;
        bit  hit, done;
        blk = int'(a) >> 4;
        s   = blk % 4;
        t   = blk / 4;
        w   = (int'(a) >> 2) % 4;
        fa  = flush_at;
        read = 1'b1; address = a; flush = 1'b0;
        done = 1'b0;
        while (!done) begin
            hit = 1'b0; way = 0;
            for (int i = 0; i < 2; i++)
                if (m_valid[s][i] && m_tag[s][i] == t) begin hit = 1'b1; way = i; end
            if (hit) begin
                step_cycle(0, 1'b0, 6'd0, mem_word(blk, w));
                last_instr = mem_word(blk, w);
                m_lru[s]   = (way == 0) ? 1 : 0;
                m_hits     = sat16(m_hits);
                done       = 1'b1;
            end else begin
                m_misses = sat16(m_misses);
                step_cycle(1, 1'b0, 6'd0, last_instr);
                for (int k = 0; k <= MEM_WAIT; k++) begin
                    flush = (k == fa);
                    step_cycle(1, 1'b1, 6'(blk), last_instr);
                end
                flush = 1'b0;
                step_cycle(1, 1'b0, 6'd0, last_instr);
                way = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
                m_valid[s][way] = 1'b1;
                m_tag[s][way]   = t;
                m_lru[s]        = (way == 0) ? 1 : 0;
                if (fa >= 0) begin
                    step_cycle(1, 1'b0, 6'd0, last_instr);
                    model_flush();
                    fa = -1;
                end
            end
        end
    endtask

    task automatic flush_task(input bit with_read, input logic [9:0] a);
        read = with_read; address = a; flush = 1'b1;
        step_cycle(with_read ? 1 : -1, 1'b0, 6'd0, last_instr);
        flush = 1'b0;
        step_cycle(1, 1'b0, 6'd0, last_instr);
        model_flush();
        if (with_read) fetch(a, -1);
        read = 1'b0;
    endtask

    task automatic idle_cycle();
        read = 1'b0; flush = 1'b0;
        step_cycle(0, 1'b0, 6'd0, last_instr);
    endtask

    // Combinational look at a new address, no clock edge.
    task automatic probe(input string name, input logic [9:0] a, input bit busy,
                         input bit chk_instr, input logic [31:0] instr);
        exp_on = 1'b0;
        read = 1'b1; address = a; flush = 1'b0;
        #1;
        check({name, "_busy"}, 32'(busywait), 32'(busy));
        if (chk_instr) check({name, "_instr"}, instruction, instr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a;
        int         op;
        reset_n = 1'b0; read = 1'b0; flush = 1'b0; address = '0;
        model_flush();
        last_instr = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_busywait", 32'(busywait), 32'd0);
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_instruction", instruction, 32'd0);
        check("reset_mem_address", 32'(mem_address), 32'd0);
        reset_n = 1'b1;
        idle_cycle();

        // Cold miss then hits in the same block.
        fetch(10'h000, -1);
        probe("t1_d0", 10'h000, 1'b0, 1'b1, 32'hA000_0000);
        fetch(10'h004, -1);
        probe("t2_d1", 10'h004, 1'b0, 1'b1, 32'hA000_0001);
        fetch(10'h00C, -1);
        probe("t2_d3", 10'h00C, 1'b0, 1'b1, 32'hA000_0003);
`ifdef ICACHE_PERF_EN
        check("t6_miss_count", 32'(miss_count), 32'd1);
        check("t6_hit_count", 32'(hit_count), 32'd3);
`endif
        idle_cycle();

        // LRU eviction in set 0.
        fetch(10'h040, -1);
        fetch(10'h000, -1);
        fetch(10'h080, -1);
        probe("t3_hit000", 10'h000, 1'b0, 1'b1, 32'hA000_0000);
        fetch(10'h000, -1);
        probe("t3_miss040", 10'h040, 1'b1, 1'b0, 32'h0);
        fetch(10'h040, -1);

        // Flush in IDLE, flush during refill, read+flush.
        flush_task(1'b0, 10'h000);
        probe("t4_miss_after_flush", 10'h000, 1'b1, 1'b0, 32'h0);
        fetch(10'h000, -1);
        fetch(10'h010, 2);
        flush_task(1'b1, 10'h020);

        // Reset in the middle of a refill.
        read = 1'b1; address = 10'h050; flush = 1'b0;
        step_cycle(1, 1'b0, 6'd0, last_instr);
        for (int k = 0; k < 3; k++) step_cycle(1, 1'b1, 6'h05, last_instr);
        exp_on  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t5_mem_read_async", 32'(mem_read), 32'd0);
        check("t5_busywait_async", 32'(busywait), 32'd0);
        check("t5_instruction_async", instruction, 32'd0);
        model_flush();
        last_instr = '0;
        @(posedge clock); #1;
        check("t5_busywait_held", 32'(busywait), 32'd0);
        reset_n = 1'b1;
        fetch(10'h000, -1);

        // Randomised traffic over a small working set to force conflicts.
        for (int n = 0; n < 150; n++) begin
            a  = {2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'b00};
            op = int'($urandom_range(0, 19));
            if (op == 0)      flush_task(1'($urandom_range(0, 1)), a);
            else if (op == 1) fetch(a, int'($urandom_range(0, MEM_WAIT)));
            else if (op == 2) idle_cycle();
            else              fetch(a, -1);
        end
`ifdef ICACHE_PERF_EN
        check("final_hit_count", 32'(hit_count), 32'(m_hits));
        check("final_miss_count", 32'(miss_count), 32'(m_misses));
`endif
        exp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
